// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for the bit-serial add/subtract responder.
// The slave modport is the arithmetic unit; the master is the execute-stage requester.
interface serial_addsub_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             cf;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, res, cf, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, res, cf, zero, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor, one result bit per cycle, LSB first.
// Build option SERIAL_ADDSUB_PIPE_ACCEPT_EN: accept the next op on the output handshake edge.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready high)
// BUSY  | shifting one bit per cycle through the serial full adder
// DONE  | result and flags presented on out_valid until out_ready
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt;
  logic             c;
  logic             sel_q;
  logic             a_msb;
  logic             b_msb;
  logic             cf_q;
  logic             zero_q;
  logic             ov_q;

  logic             in_ready_c;
  logic             accept;
  logic             sum_bit;
  logic             c_next;
  logic [WIDTH-1:0] res_next;
  logic             cf_next;
  logic             ov_next;

  always_comb begin
    in_ready_c = 1'b0;
    if (!rst && state == IDLE) in_ready_c = 1'b1;
`ifdef SERIAL_ADDSUB_PIPE_ACCEPT_EN
    if (!rst && state == DONE) in_ready_c = bus.out_ready;
`endif
  end

  assign accept = bus.in_valid && in_ready_c;

  // Serial full adder; b was pre-inverted and carry preset for subtraction.
  assign sum_bit  = a_sh[0] ^ b_sh[0] ^ c;
  assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign res_next = {sum_bit, res_q[WIDTH-1:1]};
  assign cf_next  = sel_q ? ~c_next : c_next;

  // Overflow is judged on the original b sign, not the inverted one in b_sh.
  always_comb begin
    ov_next = 1'b0;
    if (sel_q) ov_next = (a_msb != b_msb) && (sum_bit != a_msb);
    else       ov_next = (a_msb == b_msb) && (sum_bit != a_msb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_q  <= '0;
      cnt    <= '0;
      c      <= 1'b0;
      sel_q  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cf_q   <= 1'b0;
      zero_q <= 1'b0;
      ov_q   <= 1'b0;
    end else if (accept) begin
      state <= BUSY;
      a_sh  <= bus.a;
      b_sh  <= bus.b ^ {WIDTH{bus.sel}};
      sel_q <= bus.sel;
      c     <= bus.sel;
      cnt   <= '0;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else begin
      case (state)
        BUSY: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          c     <= c_next;
          res_q <= res_next;
          cnt   <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state  <= DONE;
            cf_q   <= cf_next;
            zero_q <= (res_next == '0);
            ov_q   <= ov_next;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_q;
  assign bus.cf        = cf_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed corner cases, stall/abort scenarios and a full sweep.
// Build with SERIAL_ADDSUB_PIPE_ACCEPT_EN defined to exercise the pipelined-accept variant.
module tb_serial_addsub;
  localparam int W = 4;
`ifdef SERIAL_ADDSUB_PIPE_ACCEPT_EN
  localparam int PIPE_GAP = 0;
`else
  localparam int PIPE_GAP = 1;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         cf;
    logic         zero;
    logic         ov;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(W)) bus ();
  serial_addsub #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  resp_t exp_q[$];
  int    rise_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_hs = -1;
  int    last_acc = -1;
  bit    rand_ready = 1'b0;
  bit    prev_ov = 1'b0;
  bit    prev_hold = 1'b0;
  resp_t held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic resp_t model(input int a, input int b, input bit sel);
    resp_t r;
    int m, sa, sb, u, s;
    m  = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    if (!sel) begin
      u    = a + b;
      s    = sa + sb;
      r.cf = (u >= m);
    end else begin
      u    = a - b;
      s    = sa - sb;
      r.cf = (a < b);
    end
    r.res  = u[W-1:0];
    r.zero = (r.res == '0);
    r.ov   = (s < -(m / 2)) || (s > m / 2 - 1);
    return r;
  endfunction

  function automatic resp_t mk(input logic [W-1:0] r, input logic c, input logic z, input logic o);
    resp_t t;
    t = {r, c, z, o};
    return t;
  endfunction

  function automatic resp_t dut_resp();
    resp_t t;
    t = {bus.res, bus.cf, bus.zero, bus.overflow};
    return t;
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency, hold stability and scoreboard pops, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        rise_q.push_back(cyc + 1 + W);
        last_acc = cyc + 1;
      end
      if (bus.out_valid && !prev_ov) begin
        if (rise_q.size() == 0) check("latency_unexpected_valid", 32'd1, 32'd0);
        else check("latency", cyc, rise_q.pop_front());
      end
      if (prev_hold) begin
        check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("hold_data", {25'd0, dut_resp()}, {25'd0, held});
      end
      if (bus.out_valid && !bus.out_ready) check("in_ready_in_stall", {31'd0, bus.in_ready}, 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("result_unexpected", 32'd1, 32'd0);
        else check("result", {25'd0, dut_resp()}, {25'd0, exp_q.pop_front()});
        last_hs = cyc + 1;
      end
      prev_ov   = bus.out_valid;
      prev_hold = bus.out_valid && !bus.out_ready;
      held      = dut_resp();
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel, input resp_t exp);
    bit ok;
    bus.a = a;
    bus.b = b;
    bus.sel = sel;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    bus.sel = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pending", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_outputs"}, {25'd0, dut_resp()}, 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sel = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_por", {31'd0, bus.in_ready}, 32'd1);

    // Reset pulse while idle.
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_rst");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(4'b0111, 4'b0001, 1'b0, mk(4'b1000, 1'b0, 1'b0, 1'b1));
    issue(4'b0000, 4'b0001, 1'b1, mk(4'b1111, 1'b1, 1'b0, 1'b0));
    issue(4'b1000, 4'b0001, 1'b1, mk(4'b0111, 1'b0, 1'b0, 1'b1));
    issue(4'b1000, 4'b1000, 1'b0, mk(4'b0000, 1'b1, 1'b1, 1'b1));
    drain();

    // Stall in DONE for 5 cycles with the next op already waiting on in_valid.
    bus.out_ready = 1'b0;
    issue(4'd3, 4'd4, 1'b0, model(3, 4, 1'b0));
    fork
      issue(4'd5, 4'd6, 1'b1, model(5, 6, 1'b1));
      begin
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bus.out_valid) break;
        end
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    check("pipe_accept_gap", last_acc - last_hs, PIPE_GAP);
    drain();

    // Abort two cycles into BUSY.
    issue(4'd9, 4'd2, 1'b0, model(9, 2, 1'b0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("busy_rst");
    exp_q.delete();
    rise_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      check("no_valid_after_abort", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    issue(4'b0011, 4'b0101, 1'b1, mk(4'b1110, 1'b1, 1'b0, 1'b0));
    drain();

    // Exhaustive sweep, then random traffic, both under random backpressure.
    rand_ready = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < (1 << W); a++)
        for (int b = 0; b < (1 << W); b++) begin
          issue(W'(a), W'(b), 1'(s), model(a, b, 1'(s)));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
    for (int i = 0; i < 100; i++) begin
      int ra, rb;
      bit rs;
      ra = $urandom_range(0, (1 << W) - 1);
      rb = $urandom_range(0, (1 << W) - 1);
      rs = 1'($urandom);
      issue(W'(ra), W'(rb), rs, model(ra, rb, rs));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    @(posedge clk); #3;
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
